// File: rtl/lvt_regfile.sv
// lvt_regfile: multi-write-port register file with live-value table, write bypass, busy scoreboard and post-reset clear sweep
module lvt_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int DEPTH = 32,
  parameter int HARDWIRE_ZERO = 1,
  parameter int BYPASS = 1,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int LW = NUM_WRITE_PORTS > 1 ? $clog2(NUM_WRITE_PORTS) : 1
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic                                    i_stall,
  input  logic [NUM_WRITE_PORTS-1:0]              i_write_enable,
  input  logic [NUM_WRITE_PORTS*AW-1:0]           i_write_addr,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0]   i_write_data,
  input  logic                                    i_reserve_valid,
  input  logic [AW-1:0]                           i_reserve_addr,
  input  logic [NUM_READ_PORTS*AW-1:0]            i_read_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]    o_read_data,
  output logic [NUM_READ_PORTS-1:0]               o_read_busy,
  output logic                                    o_init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [AW-1:0] cnt;
  logic [LW-1:0] lvt [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DATA_WIDTH-1:0] bank [NUM_WRITE_PORTS][NUM_READ_PORTS][DEPTH];
  logic [NUM_WRITE_PORTS-1:0] we;
  logic [AW-1:0] wa [NUM_WRITE_PORTS];
  logic [DATA_WIDTH-1:0] wd [NUM_WRITE_PORTS];
  logic rv;
  function automatic logic legal(input logic [AW-1:0] a);
    return 32'(a) < DEPTH && !(HARDWIRE_ZERO != 0 && a == '0);
  endfunction
  assign o_init_done = state == RUN;
  assign rv = i_reserve_valid & ~i_stall & o_init_done & legal(i_reserve_addr);
  for (genvar w = 0; w < NUM_WRITE_PORTS; w++) begin : g_wr
    assign wa[w] = i_write_addr[w*AW +: AW];
    assign wd[w] = i_write_data[w*DATA_WIDTH +: DATA_WIDTH];
    assign we[w] = i_write_enable[w] & ~i_stall & o_init_done & legal(wa[w]);
  end
  // Ascending port loop: the highest-index writer to an address lands last in the LVT.
  // A reservation is applied after the write clears so a new producer keeps the register busy.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= INIT;
      cnt <= '0;
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) lvt[i] <= '0;
    end else if (state == INIT) begin
      lvt[cnt] <= '0;
      cnt <= cnt + 1'b1;
      if (32'(cnt) == DEPTH - 1) state <= RUN;
    end else begin
      for (int w = 0; w < NUM_WRITE_PORTS; w++)
        if (we[w]) begin
          lvt[wa[w]] <= LW'(w);
          busy[wa[w]] <= 1'b0;
        end
      if (rv) busy[i_reserve_addr] <= 1'b1;
    end
  // Banks carry no reset; the sweep zeroes the port-0 banks that the cleared LVT points at.
  always_ff @(posedge i_clk)
    for (int w = 0; w < NUM_WRITE_PORTS; w++)
      for (int r = 0; r < NUM_READ_PORTS; r++)
        if (state == INIT && w == 0) bank[w][r][cnt] <= '0;
        else if (we[w]) bank[w][r][wa[w]] <= wd[w];
  for (genvar r = 0; r < NUM_READ_PORTS; r++) begin : g_rd
    logic [AW-1:0] a;
    logic [DATA_WIDTH-1:0] rd;
    logic bs;
    assign a = i_read_addr[r*AW +: AW];
    always_comb begin
      rd = bank[lvt[a]][r][a];
      bs = busy[a];
      for (int w = 0; w < NUM_WRITE_PORTS; w++)
        if (BYPASS != 0 && we[w] && wa[w] == a) begin
          rd = wd[w];
          bs = 1'b0;
        end
      if (!o_init_done || !legal(a)) begin
        rd = '0;
        bs = 1'b0;
      end
    end
    assign o_read_data[r*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign o_read_busy[r] = bs;
  end
endmodule

// File: tb/tb_lvt_regfile.sv
// tb_lvt_regfile: directed table-driven bench for lvt_regfile (integer and FP configurations)
module tb_lvt_regfile;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic stall, rv, done;
  logic [1:0] we, rbusy;
  logic [9:0] wa, raddr;
  logic [63:0] wd, rdata;
  logic [4:0] rad;
  logic [1:0] we1;
  logic [9:0] wa1;
  logic [127:0] wd1;
  logic [14:0] raddr1;
  logic [191:0] rdata1;
  logic [2:0] rbusy1;
  logic done1;
  int n = 0;
  int err = 0;
  lvt_regfile u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_write_enable(we), .i_write_addr(wa),
    .i_write_data(wd), .i_reserve_valid(rv), .i_reserve_addr(rad), .i_read_addr(raddr),
    .o_read_data(rdata), .o_read_busy(rbusy), .o_init_done(done)
  );
  lvt_regfile #(.DATA_WIDTH(64), .NUM_READ_PORTS(3), .HARDWIRE_ZERO(0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(1'b0), .i_write_enable(we1), .i_write_addr(wa1),
    .i_write_data(wd1), .i_reserve_valid(1'b0), .i_reserve_addr(5'd0), .i_read_addr(raddr1),
    .o_read_data(rdata1), .o_read_busy(rbusy1), .o_init_done(done1)
  );
  typedef struct {
    logic [1:0] we;
    logic [4:0] wa0, wa1;
    logic [31:0] wd0, wd1;
    logic st, rv;
    logic [4:0] rsa, ra0, ra1;
    logic [31:0] d0, d1;
    logic b0, b1;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic idle();
    stall = 0; we = 0; wa = 0; wd = 0; rv = 0; rad = 0;
    we1 = 0; wa1 = 0; wd1 = 0;
  endtask
  task automatic wait_init(input string nm);
    int k = 0;
    while (!done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(nm, 64'(k), 64'd32);
  endtask
  initial begin
    rst_n = 0;
    idle();
    raddr = {5'd5, 5'd3};
    raddr1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data", rdata, 64'd0);
    chk("rst_busy", 64'(rbusy), 64'd0);
    rst_n = 1;
    #1;
    chk("init_data", rdata, 64'd0);
    wait_init("init_len");
    chk("fp_init_done", 64'(done1), 64'd1);
    vq.push_back('{2'b11, 5'd5, 5'd5, 32'hAAAA0001, 32'h55550002, 1'b0, 1'b0, 5'd0, 5'd5, 5'd6, 32'h55550002, 32'h0, 1'b0, 1'b0});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h55550002, 32'h0, 1'b0, 1'b0});
    vq.push_back('{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h55550002, 1'b0, 1'b0});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h55550002, 1'b0, 1'b0});
    vq.push_back('{2'b01, 5'd5, 5'd0, 32'h11111111, 32'h0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd3, 32'h11111111, 32'h0, 1'b0, 1'b0});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd3, 32'h11111111, 32'h0, 1'b0, 1'b0});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd5, 32'h0, 32'h11111111, 1'b0, 1'b0});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h0, 32'h11111111, 1'b1, 1'b0});
    vq.push_back('{2'b10, 5'd0, 5'd7, 32'h0, 32'h1234, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h1234, 32'h1234, 1'b0, 1'b0});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h1234, 32'h11111111, 1'b0, 1'b0});
    vq.push_back('{2'b01, 5'd7, 5'd0, 32'h5678, 32'h0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h5678, 32'h5678, 1'b0, 1'b0});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h5678, 32'h5678, 1'b1, 1'b1});
    vq.push_back('{2'b10, 5'd0, 5'd9, 32'h0, 32'h9999, 1'b0, 1'b0, 5'd0, 5'd9, 5'd7, 32'h9999, 32'h5678, 1'b0, 1'b1});
    vq.push_back('{2'b11, 5'd9, 5'd9, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 32'h9999, 32'h9999, 1'b0, 1'b0});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd7, 32'h9999, 32'h5678, 1'b0, 1'b1});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h9999, 1'b0, 1'b0});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h5678, 1'b0, 1'b1});
    vq.push_back('{2'b01, 5'd7, 5'd0, 32'hCAFE, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'hCAFE, 1'b0, 1'b0});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd9, 32'hCAFE, 32'h9999, 1'b0, 1'b0});
    vq.push_back('{2'b11, 5'd4, 5'd3, 32'h44, 32'h33, 1'b0, 1'b0, 5'd0, 5'd4, 5'd3, 32'h44, 32'h33, 1'b0, 1'b0});
    vq.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd4, 32'h33, 32'h44, 1'b0, 1'b0});
    foreach (vq[i]) begin
      @(negedge clk);
      stall = vq[i].st; we = vq[i].we; wa = {vq[i].wa1, vq[i].wa0};
      wd = {vq[i].wd1, vq[i].wd0}; rv = vq[i].rv; rad = vq[i].rsa; raddr = {vq[i].ra1, vq[i].ra0};
      #1;
      chk($sformatf("v%0d d0", i), rdata[31:0], 64'(vq[i].d0));
      chk($sformatf("v%0d d1", i), rdata[63:32], 64'(vq[i].d1));
      chk($sformatf("v%0d b0", i), 64'(rbusy[0]), 64'(vq[i].b0));
      chk($sformatf("v%0d b1", i), 64'(rbusy[1]), 64'(vq[i].b1));
    end
    @(negedge clk);
    idle();
    we = 2'b10; wa = {5'd12, 5'd0}; wd = {32'hBAD0BAD0, 32'h0};
    @(negedge clk);
    idle();
    raddr = {5'd5, 5'd12};
    #1;
    chk("garbage_x12", rdata[31:0], 64'hBAD0BAD0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sweep10_done", 64'(done), 64'd0);
    rst_n = 0;
    #1;
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_data", rdata, 64'd0);
    @(negedge clk);
    rst_n = 1;
    wait_init("restart_len");
    chk("clr_x12", rdata[31:0], 64'd0);
    chk("clr_x5", rdata[63:32], 64'd0);
    @(negedge clk);
    we1 = 2'b01; wa1 = {5'd0, 5'd0}; wd1 = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}; raddr1 = {5'd0, 5'd1, 5'd2};
    #1;
    chk("fp_x0_byp", rdata1[191:128], 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    idle();
    #1;
    chk("fp_x0_rd", rdata1[191:128], 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    we1 = 2'b11; wa1 = {5'd5, 5'd5}; wd1 = {64'h5555_0002_5555_0002, 64'hAAAA_0001_AAAA_0001};
    raddr1 = {5'd5, 5'd0, 5'd5};
    #1;
    chk("fp_byp_r0", rdata1[63:0], 64'h5555_0002_5555_0002);
    chk("fp_byp_r2", rdata1[191:128], 64'h5555_0002_5555_0002);
    @(negedge clk);
    idle();
    raddr1 = {5'd0, 5'd5, 5'd0};
    #1;
    chk("fp_rd_r1", rdata1[127:64], 64'h5555_0002_5555_0002);
    chk("fp_rd_r2", rdata1[191:128], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("fp_busy", 64'(rbusy1), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule

// File: doc/lvt_regfile.md
# lvt_regfile

Multi-write-port register file with a live-value table (LVT), same-cycle write bypass, a per-register busy scoreboard and a post-reset clear sequencer. It sits in the writeback stage and serves either the integer file (x0 hardwired zero) or the FP file (3 read ports, 64-bit). It is the successor to the single-write-port regfile and lets two retiring pipes (e.g. ALU and load/FP) write in the same cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- NUM_READ_PORTS, 2, combinational read ports
- NUM_WRITE_PORTS, 2, write ports, 1..4
- DEPTH, 32, number of registers; AW = $clog2(DEPTH)
- HARDWIRE_ZERO, 1, register 0 reads 0, is never written and is never busy
- BYPASS, 1, read data forwards same-cycle write data

Ports (ports are packed vectors; port k occupies slice k):
- i_clk  in  1  clock; the only clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_stall  in  1  gates all writes and reservations (not the clear sweep)
- i_write_enable  in  NUM_WRITE_PORTS  per-port write strobe
- i_write_addr  in  NUM_WRITE_PORTS*AW  per-port destination
- i_write_data  in  NUM_WRITE_PORTS*DATA_WIDTH  per-port data
- i_reserve_valid  in  1  mark a destination as pending (issue of a producer)
- i_reserve_addr  in  AW  register to mark busy
- i_read_addr  in  NUM_READ_PORTS*AW  per-port source address
- o_read_data  out  NUM_READ_PORTS*DATA_WIDTH  per-port read data
- o_read_busy  out  NUM_READ_PORTS  per-port "value not yet produced"
- o_init_done  out  1  clear sweep finished; file usable

## Operation
- Storage: NUM_WRITE_PORTS x NUM_READ_PORTS sdp_dist_ram banks; bank (w,r) is written only by port w and read by read port r. LVT: DEPTH flops of $clog2(NUM_WRITE_PORTS) bits (min 1) recording the last writer per register; read data = bank[LVT[addr]][r].
- Effective write of port w: enable & ~i_stall & o_init_done & addr < DEPTH & (addr != 0 when HARDWIRE_ZERO).
- Same-address write conflict: highest-index port wins (its bank written, LVT updated to it); lower ports' bank writes still happen but are masked by the LVT.
- Clear FSM, states INIT then RUN. On reset: state INIT, sweep counter 0. In INIT, each cycle port-0 banks get data 0 at counter, LVT[counter] <= 0, counter++; after address DEPTH-1, go to RUN. INIT ignores i_stall, all writes and reservations. RUN is terminal until reset.
- While INIT: o_read_data all zero, o_read_busy all zero.
- Busy scoreboard: DEPTH flops, reset to 0. Effective reservation (valid & ~i_stall & o_init_done, legal address) sets busy; any effective write clears its address. Same-cycle reserve and write to one address: busy ends set (new producer wins).
- Read port r, addr a: HARDWIRE_ZERO and a==0 -> data 0, busy 0. Else if BYPASS and an effective write targets a this cycle -> data from highest-index such port, busy 0. Else data from LVT-selected bank, busy = busy[a]. a >= DEPTH reads 0, busy 0.

## Timing
- Reads combinational, zero latency.
- Write visible on reads next cycle (same cycle if BYPASS); busy clear visible same cycle if BYPASS, next cycle otherwise.
- Reservation visible on o_read_busy next cycle.
- o_init_done = 0 from reset assertion; rises exactly DEPTH rising edges after i_rst_n deasserts; first write accepted on that cycle.
- Reset mid-sweep or mid-operation: LVT, busy, counter, state cleared immediately; sweep restarts from address 0.
- Outputs under reset: o_init_done 0, o_read_data 0, o_read_busy 0.

## Test plan
- Reset release, DEPTH=32 -> o_init_done low for 32 cycles, high on the 33rd; all reads return 0 afterward, even after banks pre-loaded with garbage.
- Port 0 writes x5=0xAAAA_0001 and port 1 writes x5=0x5555_0002 same cycle -> x5 reads 0x5555_0002 next cycle; with BYPASS, same cycle.
- Write x0=0xFFFF_FFFF with HARDWIRE_ZERO=1 -> x0 reads 0; with HARDWIRE_ZERO=0 -> reads 0xFFFF_FFFF.
- Reserve x7, then port 1 writes x7=0x1234 two cycles later -> busy 1 for reads in between, busy 0 and data 0x1234 in write cycle (BYPASS=1); reserve+write x7 same cycle -> busy stays 1.
- i_stall high with writes and reserve to x9 -> x9 data and busy unchanged.
- Assert i_rst_n low at sweep address 10 -> o_init_done stays low, sweep restarts, done 32 cycles after release; FP config (64-bit, 3 read ports) repeats the write/bypass test.
